// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the RV32I multicycle control FSM.
// State, select and opcode encodings plus the per-state control word decode.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_EXEC_U = 4'd5,
    ST_WB_ALU = 4'd6,
    ST_ADDR   = 4'd7,
    ST_MEM_RD = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_MEM_WR = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JAL    = 4'd12,
    ST_JALR   = 4'd13,
    ST_TRAP   = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_U, CLS_MEM, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;
  localparam logic [1:0] ALU_A_RS1     = 2'd0;
  localparam logic [1:0] ALU_A_PC      = 2'd1;
  localparam logic [1:0] ALU_A_ZERO    = 2'd2;
  localparam logic [1:0] ALU_B_RS2     = 2'd0;
  localparam logic [1:0] ALU_B_IMM     = 2'd1;
  localparam logic [1:0] ALU_B_FOUR    = 2'd2;
  localparam logic [1:0] ALUOP_ADD     = 2'd0;
  localparam logic [1:0] ALUOP_FUNCT   = 2'd1;
  localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
  localparam logic [1:0] WB_SEL_MDR    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;

  // in_fetch/in_branch are later qualified by mem_ready/br_taken
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] pc_src;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       in_fetch;
    logic       in_branch;
    logic       pc_we_fixed;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s, input logic is_lui);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.pc_src    = PC_SRC_ALU;
        c.alu_a_sel = ALU_A_PC;
        c.alu_b_sel = ALU_B_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.in_fetch  = 1'b1;
      end
      ST_DECODE: begin
        c.alu_a_sel = ALU_A_PC;
        c.alu_b_sel = ALU_B_IMM;
      end
      ST_EXEC_R: begin
        c.alu_a_sel = ALU_A_RS1;
        c.alu_b_sel = ALU_B_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        c.alu_b_sel = ALU_B_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_U: begin
        c.alu_a_sel = is_lui ? ALU_A_ZERO : ALU_A_PC;
        c.alu_b_sel = ALU_B_IMM;
      end
      ST_WB_ALU: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WB_SEL_ALUOUT;
      end
      ST_ADDR:   c.alu_b_sel = ALU_B_IMM;
      ST_MEM_RD: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      ST_WB_MEM: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WB_SEL_MDR;
      end
      ST_MEM_WR: begin
        c.mem_req      = 1'b1;
        c.mem_we       = 1'b1;
        c.mem_addr_sel = 1'b1;
      end
      ST_BRANCH: begin
        c.pc_src    = PC_SRC_ALUOUT;
        c.in_branch = 1'b1;
      end
      ST_JAL: begin
        c.pc_src      = PC_SRC_ALUOUT;
        c.pc_we_fixed = 1'b1;
        c.rf_we       = 1'b1;
        c.wb_sel      = WB_SEL_PC4;
      end
      ST_JALR: begin
        c.alu_b_sel   = ALU_B_IMM;
        c.pc_src      = PC_SRC_JALR;
        c.pc_we_fixed = 1'b1;
        c.rf_we       = 1'b1;
        c.wb_sel      = WB_SEL_PC4;
      end
      ST_TRAP:   c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: maps IR[6:0] to the instruction class
// that DECODE dispatches on, plus the load/store and LUI/AUIPC sub-selects.
module mc_opcode_class
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       is_store,
  output logic       is_lui
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPCODE_OP:                  op_class = CLS_R;
      OPCODE_OP_IMM:              op_class = CLS_I;
      OPCODE_LUI, OPCODE_AUIPC:   op_class = CLS_U;
      OPCODE_LOAD, OPCODE_STORE:  op_class = CLS_MEM;
      OPCODE_BRANCH:              op_class = CLS_BRANCH;
      OPCODE_JAL:                 op_class = CLS_JAL;
      OPCODE_JALR:                op_class = CLS_JALR;
      default:                    op_class = CLS_ILLEGAL;
    endcase
  end

  assign is_store = (opcode == OPCODE_STORE);
  assign is_lui   = (opcode == OPCODE_LUI);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM. Optional MC_CTRL_PERF_EN adds cycle and
// retired-instruction counters (cycle_cnt, instret_cnt).
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int unsigned RESET_IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  state_t    state;
  state_t    state_nx;
  ctrl_t     ctrl;
  logic [3:0] idle_cnt;
  op_class_t op_class;
  logic      is_store;
  logic      is_lui;

  mc_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class),
    .is_store (is_store),
    .is_lui   (is_lui)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (idle_cnt == IDLE_LAST) state_nx = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_nx = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CLS_R:      state_nx = ST_EXEC_R;
          CLS_I:      state_nx = ST_EXEC_I;
          CLS_U:      state_nx = ST_EXEC_U;
          CLS_MEM:    state_nx = ST_ADDR;
          CLS_BRANCH: state_nx = ST_BRANCH;
          CLS_JAL:    state_nx = ST_JAL;
          CLS_JALR:   state_nx = ST_JALR;
          default:    state_nx = ST_TRAP;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I, ST_EXEC_U: state_nx = ST_WB_ALU;
      ST_ADDR:   state_nx = is_store ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (mem_ready) state_nx = ST_WB_MEM;
      ST_MEM_WR: if (mem_ready) state_nx = ST_FETCH;
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR: state_nx = ST_FETCH;
      ST_TRAP:   state_nx = ST_TRAP;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // The control word is registered from the next state, so outputs are a
  // pure function of the state register while still arriving on time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      idle_cnt <= '0;
`ifdef MC_CTRL_PERF_EN
      cycle_cnt   <= '0;
      instret_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      ctrl  <= state_ctrl(state_nx, is_lui);
      if (state == ST_IDLE) idle_cnt <= idle_cnt + 4'd1;
`ifdef MC_CTRL_PERF_EN
      if (state != ST_IDLE && state != ST_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_nx == ST_FETCH && state != ST_IDLE && state != ST_FETCH)
        instret_cnt <= instret_cnt + 32'd1;
`endif
    end
  end

  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign pc_src       = ctrl.pc_src;
  assign alu_a_sel    = ctrl.alu_a_sel;
  assign alu_b_sel    = ctrl.alu_b_sel;
  assign alu_op       = ctrl.alu_op;
  assign rf_we        = ctrl.rf_we;
  assign wb_sel       = ctrl.wb_sel;
  assign illegal      = ctrl.illegal;
  assign ir_we        = ctrl.in_fetch & mem_ready;
  assign pc_we        = ctrl.pc_we_fixed | (ctrl.in_fetch & mem_ready) |
                        (ctrl.in_branch & br_taken);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed vector table, hand-written
// corner sequences and a random instruction stream against a schedule model.
module tb_mc_control_fsm;

  localparam int IDLE_N = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic       br;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_taken, mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, illegal;
  logic [1:0] pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  outs_t got;

  int n_pass = 0;
  int n_checks = 0;
  vec_t q[$];
  vec_t tbl[11];
  logic [6:0] legal_ops[9];

  always #5 clk = ~clk;

  mc_control_fsm #(.RESET_IDLE_CYCLES(IDLE_N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  assign got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, illegal};

  function automatic outs_t mk(input logic rq, we, as, ir, pw,
                               input logic [1:0] ps, a, b, op,
                               input logic rf, input logic [1:0] wb,
                               input logic il);
    return {rq, we, as, ir, pw, ps, a, b, op, rf, wb, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic br, input logic rdy);
    opcode    = op;
    br_taken  = br;
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input logic [6:0] op, input logic br, input logic rdy, input outs_t e);
    vec_t v;
    v.op = op; v.br = br; v.rdy = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // Reference schedule: one record per clock for a whole instruction, from
  // the first FETCH cycle up to (not including) the next FETCH.
  task automatic build_insn(input logic [6:0] op, input logic br, input int fw, input int mw);
    outs_t mem_rd, mem_wr;
    mem_rd = mk(1,0,1,0,0,0,0,0,0,0,0,0);
    mem_wr = mk(1,1,1,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < fw; i++) push(7'($urandom), rb(), 1'b0, mk(1,0,0,0,0,0,1,2,0,0,0,0));
    push(7'($urandom), rb(), 1'b1, mk(1,0,0,1,1,0,1,2,0,0,0,0));
    push(op, rb(), rb(), mk(0,0,0,0,0,0,1,1,0,0,0,0));
    case (op)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
        if (op == OPC_OP)          push(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,1,0,0,0));
        else if (op == OPC_OP_IMM) push(op, rb(), rb(), mk(0,0,0,0,0,0,0,1,1,0,0,0));
        else if (op == OPC_LUI)    push(op, rb(), rb(), mk(0,0,0,0,0,0,2,1,0,0,0,0));
        else                       push(op, rb(), rb(), mk(0,0,0,0,0,0,1,1,0,0,0,0));
        push(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0));
      end
      OPC_LOAD: begin
        push(op, rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,0,0));
        for (int i = 0; i < mw; i++) push(op, rb(), 1'b0, mem_rd);
        push(op, rb(), 1'b1, mem_rd);
        push(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,1,0));
      end
      OPC_STORE: begin
        push(op, rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,0,0));
        for (int i = 0; i < mw; i++) push(op, rb(), 1'b0, mem_wr);
        push(op, rb(), 1'b1, mem_wr);
      end
      OPC_BRANCH: push(op, br, rb(), mk(0,0,0,0,br,1,0,0,0,0,0,0));
      OPC_JAL:    push(op, rb(), rb(), mk(0,0,0,0,1,1,0,0,0,1,2,0));
      OPC_JALR:   push(op, rb(), rb(), mk(0,0,0,0,1,2,0,1,0,1,2,0));
      default:
        for (int i = 0; i < 4; i++) push(7'($urandom), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,0,1));
    endcase
  endtask

  task automatic run_q(input string label, input int limit);
    int n;
    n = (limit < 0 || limit > q.size()) ? q.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus(q[i].op, q[i].br, q[i].rdy);
      #1;
      checkOutput($sformatf("%s[%0d]", label, i), q[i].exp);
    end
    q.delete();
  endtask

  // Leaves the DUT in the last IDLE cycle; the next edge enters FETCH.
  task automatic do_reset(input string label);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(7'($urandom), rb(), 1'b0);
    @(negedge clk);
    #1;
    checkOutput({label, "_in_reset"}, '0);
    rst_n = 1'b1;
    applyStimulus(7'($urandom), rb(), 1'b1);
    for (int i = 0; i < IDLE_N - 1; i++) begin
      @(negedge clk);
      applyStimulus(7'($urandom), rb(), rb());
      #1;
      checkOutput($sformatf("%s_idle[%0d]", label, i), '0);
    end
  endtask

  initial begin
    legal_ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                  OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    // addi x1,x0,5 ; beq taken ; beq not taken ; then FETCH stalling
    tbl[0]  = '{7'h00, 1'b0, 1'b1, mk(1,0,0,1,1,0,1,2,0,0,0,0)};
    tbl[1]  = '{7'h13, 1'b0, 1'b1, mk(0,0,0,0,0,0,1,1,0,0,0,0)};
    tbl[2]  = '{7'h13, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,1,1,0,0,0)};
    tbl[3]  = '{7'h13, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,0,0)};
    tbl[4]  = '{7'h13, 1'b0, 1'b1, mk(1,0,0,1,1,0,1,2,0,0,0,0)};
    tbl[5]  = '{7'h63, 1'b0, 1'b1, mk(0,0,0,0,0,0,1,1,0,0,0,0)};
    tbl[6]  = '{7'h63, 1'b1, 1'b1, mk(0,0,0,0,1,1,0,0,0,0,0,0)};
    tbl[7]  = '{7'h63, 1'b1, 1'b1, mk(1,0,0,1,1,0,1,2,0,0,0,0)};
    tbl[8]  = '{7'h63, 1'b1, 1'b1, mk(0,0,0,0,0,0,1,1,0,0,0,0)};
    tbl[9]  = '{7'h63, 1'b0, 1'b1, mk(0,0,0,0,0,1,0,0,0,0,0,0)};
    tbl[10] = '{7'h63, 1'b0, 1'b0, mk(1,0,0,0,0,0,1,2,0,0,0,0)};

    rst_n = 1'b0;
    applyStimulus(7'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    do_reset("init");

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i].op, tbl[i].br, tbl[i].rdy);
      #1;
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // lw with three wait cycles, then the remaining instruction kinds
    build_insn(OPC_LOAD, 1'b0, 0, 3);
    run_q("lw_wait3", -1);
    build_insn(OPC_JALR, 1'b0, 0, 0);
    run_q("jalr", -1);
    build_insn(OPC_STORE, 1'b0, 1, 2);
    run_q("sw_wait", -1);
    build_insn(OPC_LUI, 1'b0, 0, 0);
    run_q("lui", -1);
    build_insn(OPC_AUIPC, 1'b0, 2, 0);
    run_q("auipc", -1);
    build_insn(OPC_JAL, 1'b0, 0, 0);
    run_q("jal", -1);
    build_insn(OPC_OP, 1'b0, 0, 0);
    run_q("op", -1);

    for (int n = 0; n < 60; n++) begin
      build_insn(legal_ops[$urandom_range(0, 8)], rb(), $urandom_range(0, 2), $urandom_range(0, 3));
      run_q($sformatf("rand%0d", n), -1);
    end

`ifdef MC_CTRL_PERF_EN
    do_reset("perf");
    build_insn(OPC_OP_IMM, 1'b0, 0, 0);
    build_insn(OPC_OP_IMM, 1'b0, 0, 0);
    run_q("perf_addi", -1);
    @(negedge clk);
    applyStimulus(7'h00, 1'b0, 1'b0);
    #1;
    check_val("instret_cnt", instret_cnt, 32'd2);
    check_val("cycle_cnt", cycle_cnt, 32'd8);
`endif

    // Reset arriving while a store waits on memory
    do_reset("pre_sw");
    build_insn(OPC_STORE, 1'b0, 0, 6);
    run_q("sw_abort", 5);
    do_reset("sw_abort");

    // Illegal opcode traps until reset clears the flag
    build_insn(7'h7F, 1'b0, 0, 0);
    run_q("trap", -1);
    do_reset("trap");
    build_insn(OPC_OP_IMM, 1'b0, 0, 0);
    run_q("recover", -1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
